// File: rtl/clock_enable_gen_pkg.sv
// Shared clocking definitions for the calculator board: clock rate, ready-made
// divisors and the per-channel action encoding used by the clock-enable generator.
package clock_enable_gen_pkg;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEF_CNT_W     = 26;
  localparam int SEL_W         = 4;

  // Divisor = CLK_HZ / f - 1, because a period is DIV + 1 cycles.
  localparam int DIV_1HZ       = 49_999_999;
  localparam int DIV_2HZ       = 24_999_999;
  localparam int DIV_1KHZ      = 49_999;
  localparam int DIV_SCAN_1KHZ = DIV_1KHZ;

  typedef enum logic [2:0] {
    OP_HOLD      = 3'd0,
    OP_COUNT     = 3'd1,
    OP_RELOAD    = 3'd2,
    OP_SYNC      = 3'd3,
    OP_LOAD_IDLE = 3'd4
  } chan_op_t;

  function automatic int div_for_hz(input int hz);
    return CLK_HZ / hz - 1;
  endfunction

endpackage

// File: rtl/clock_enable_gen_if.sv
// Control/status bundle of the clock-enable generator: divisor load port,
// run enables, phase sync, and the tick / square-wave outputs.
interface clock_enable_gen_if
  import clock_enable_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = DEF_CNT_W
);

  // LOAD_in is a one-cycle strobe with no back-pressure: it is always accepted
  // on the edge where it is high, with LOAD_SEL_in and DIV_in qualified by it.
  logic [CHANNELS-1:0]  EN_in;
  logic                 LOAD_in;
  logic [SEL_W-1:0]     LOAD_SEL_in;
  logic [CNT_W-1:0]     DIV_in;
  logic                 SYNC_in;
  logic [CHANNELS-1:0]  TICK_out;
  logic [CHANNELS-1:0]  SQW_out;
  chan_op_t [CHANNELS-1:0] OP_dbg;

  modport master (
    output EN_in, LOAD_in, LOAD_SEL_in, DIV_in, SYNC_in,
    input  TICK_out, SQW_out, OP_dbg
  );

  modport slave (
    input  EN_in, LOAD_in, LOAD_SEL_in, DIV_in, SYNC_in,
    output TICK_out, SQW_out, OP_dbg
  );

endinterface

// File: rtl/clock_enable_gen_clk_en_channel.sv
// One divider channel: down-counter with active/pending divisor, registered
// single-cycle tick and toggling square wave.
module clock_enable_gen_clk_en_channel
  import clock_enable_gen_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DIV_1HZ
) (
  input  logic             CLK_in,
  input  logic             RSTn_in,
  input  logic             EN_in,
  input  logic             LOAD_in,
  input  logic [CNT_W-1:0] DIV_in,
  input  logic             SYNC_in,
  output logic             TICK_out,
  output logic             SQW_out,
  output chan_op_t         OP_dbg
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] div_pending;
  logic             pending;

  logic [CNT_W-1:0] pend_div_nxt;
  logic             pend_nxt;
  logic [CNT_W-1:0] reload_div;
  chan_op_t         op;

  // A load on this edge is folded in before choosing the reload value, so a
  // load coinciding with terminal count or SYNC already uses the new divisor.
  always_comb begin
    pend_div_nxt = div_pending;
    pend_nxt     = pending;
    op           = OP_HOLD;
    if (LOAD_in) begin
      pend_div_nxt = DIV_in;
      pend_nxt     = 1'b1;
    end
    reload_div = pend_nxt ? pend_div_nxt : div_active;
    if (SYNC_in)           op = OP_SYNC;
    else if (!EN_in)       op = LOAD_in ? OP_LOAD_IDLE : OP_HOLD;
    else if (cnt == '0)    op = OP_RELOAD;
    else                   op = OP_COUNT;
  end

  always_ff @(posedge CLK_in) begin
    if (!RSTn_in) begin
      cnt         <= DEF_DIV;
      div_active  <= DEF_DIV;
      div_pending <= DEF_DIV;
      pending     <= 1'b0;
      TICK_out    <= 1'b0;
      SQW_out     <= 1'b0;
    end else begin
      case (op)
        OP_SYNC: begin
          cnt         <= reload_div;
          div_active  <= reload_div;
          div_pending <= pend_div_nxt;
          pending     <= 1'b0;
          TICK_out    <= 1'b0;
          SQW_out     <= 1'b0;
        end
        OP_RELOAD: begin
          cnt         <= reload_div;
          div_active  <= reload_div;
          div_pending <= pend_div_nxt;
          pending     <= 1'b0;
          TICK_out    <= 1'b1;
          SQW_out     <= ~SQW_out;
        end
        OP_COUNT: begin
          cnt         <= cnt - ONE;
          div_pending <= pend_div_nxt;
          pending     <= pend_nxt;
          TICK_out    <= 1'b0;
        end
        // A stopped channel takes a new divisor at once; there is no period to finish.
        OP_LOAD_IDLE: begin
          cnt         <= DIV_in;
          div_active  <= DIV_in;
          div_pending <= DIV_in;
          pending     <= 1'b0;
          TICK_out    <= 1'b0;
        end
        default: begin
          TICK_out    <= 1'b0;
        end
      endcase
    end
  end

  assign OP_dbg = op;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: decodes divisor loads to
// one channel and fans SYNC out to all of them.
module clock_enable_gen
  import clock_enable_gen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DIV_1HZ
) (
  input  logic               CLK_in,
  input  logic               RSTn_in,
  clock_enable_gen_if.slave  bus
);

  logic [CHANNELS-1:0]     load_vec;
  logic [CHANNELS-1:0]     tick_w;
  logic [CHANNELS-1:0]     sqw_w;
  chan_op_t [CHANNELS-1:0] op_w;

  // Selects at or above CHANNELS match no channel and are dropped.
  always_comb begin
    load_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load_vec[i] = bus.LOAD_in && (bus.LOAD_SEL_in == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_enable_gen_clk_en_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .CLK_in   (CLK_in),
      .RSTn_in  (RSTn_in),
      .EN_in    (bus.EN_in[g]),
      .LOAD_in  (load_vec[g]),
      .DIV_in   (bus.DIV_in),
      .SYNC_in  (bus.SYNC_in),
      .TICK_out (tick_w[g]),
      .SQW_out  (sqw_w[g]),
      .OP_dbg   (op_w[g])
    );
  end

  assign bus.TICK_out = tick_w;
  assign bus.SQW_out  = sqw_w;
  assign bus.OP_dbg   = op_w;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: table vectors, directed multi-cycle sequences and
// random traffic against an event-time model of each channel.
module tb_clock_enable_gen;

  localparam int CH  = 4;
  localparam int CW  = 26;
  localparam int DEF = 9;

  logic CLK_in  = 1'b0;
  logic RSTn_in = 1'b0;
  always #5 CLK_in = ~CLK_in;

  clock_enable_gen_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  clock_enable_gen #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
    .CLK_in  (CLK_in),
    .RSTn_in (RSTn_in),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: each channel is described by the absolute cycle of its next tick,
  // its period, and an optional pending period.
  int cyc = 0;
  int next_tick [CH];
  int period    [CH];
  bit pend_v    [CH];
  int pend_p    [CH];
  logic [CH-1:0] m_tick = '0;
  logic [CH-1:0] m_sqw  = '0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] got_q[$];

  typedef struct {
    logic          rst_n;
    logic [CH-1:0] en;
    logic          load;
    logic [3:0]    sel;
    int            div;
    logic          sync;
    logic [CH-1:0] exp_tick;
    logic [CH-1:0] exp_sqw;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic [CH-1:0] en, input logic load,
                            input logic [3:0] sel, input int div, input logic sync);
    cyc++;
    for (int c = 0; c < CH; c++) begin
      bit ld;
      ld = load && (sel == 4'(c));
      if (!rst_n) begin
        period[c] = DEF + 1; pend_v[c] = 0; next_tick[c] = cyc + DEF + 1;
        m_tick[c] = 0; m_sqw[c] = 0;
      end else if (ld && !en[c] && !sync) begin
        period[c] = div + 1; pend_v[c] = 0; next_tick[c] = cyc + period[c];
        m_tick[c] = 0;
      end else begin
        if (ld) begin pend_v[c] = 1; pend_p[c] = div + 1; end
        if (sync) begin
          if (pend_v[c]) period[c] = pend_p[c];
          pend_v[c] = 0; next_tick[c] = cyc + period[c];
          m_tick[c] = 0; m_sqw[c] = 0;
        end else if (!en[c]) begin
          m_tick[c] = 0; next_tick[c]++;
        end else if (cyc == next_tick[c]) begin
          m_tick[c] = 1; m_sqw[c] = ~m_sqw[c];
          if (pend_v[c]) period[c] = pend_p[c];
          pend_v[c] = 0; next_tick[c] = cyc + period[c];
        end else begin
          m_tick[c] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic rst_n, input logic [CH-1:0] en, input logic load,
                      input logic [3:0] sel, input int div, input logic sync);
    @(negedge CLK_in);
    RSTn_in         = rst_n;
    bus.EN_in       = en;
    bus.LOAD_in     = load;
    bus.LOAD_SEL_in = sel;
    bus.DIV_in      = CW'(div);
    bus.SYNC_in     = sync;
    @(posedge CLK_in);
    model_step(rst_n, en, load, sel, div, sync);
    #1;
    check("tick", bus.TICK_out, m_tick);
    check("sqw", bus.SQW_out, m_sqw);
  endtask

  task automatic idle(input logic [CH-1:0] en);
    step(1'b1, en, 1'b0, 4'd0, 0, 1'b0);
  endtask

  // Steps until channel ch ticks; k is the step index of the tick, -1 on timeout.
  task automatic run_until(input int ch, input logic [CH-1:0] en, input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit && k < 0; i++) begin
      idle(en);
      if (bus.TICK_out[ch] === 1'b1) k = i;
    end
  endtask

  task automatic compare_queue(input string name);
    check_int({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check_int(name, int'(got_q.pop_front()), int'(exp_q.pop_front()));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int k;
    bus.EN_in = '0; bus.LOAD_in = 0; bus.LOAD_SEL_in = '0; bus.DIV_in = '0; bus.SYNC_in = 0;

    // Table: reset, DIV=0 on ch2 while stopped, ignored select 7, default ticks at 10 and 20.
    tbl[0] = '{rst_n: 0, en: 4'hF, load: 0, sel: 0, div: 0, sync: 0, exp_tick: 4'h0, exp_sqw: 4'h0};
    tbl[1] = '{rst_n: 1, en: 4'b1011, load: 1, sel: 2, div: 0, sync: 0, exp_tick: 4'h0, exp_sqw: 4'h0};
    for (int s = 2; s <= 20; s++) begin
      logic [CH-1:0] t, q;
      t = (s == 10 || s == 20) ? 4'hF : 4'b0100;
      q = ((s >= 10 && s < 20) ? 4'b1011 : 4'b0000) | ((s % 2 == 0) ? 4'b0100 : 4'b0000);
      tbl[s] = '{rst_n: 1, en: 4'hF, load: (s == 2), sel: (s == 2) ? 4'd7 : 4'd0,
                 div: (s == 2) ? 5 : 0, sync: 0, exp_tick: t, exp_sqw: q};
    end
    for (int s = 0; s <= 20; s++) begin
      step(tbl[s].rst_n, tbl[s].en, tbl[s].load, tbl[s].sel, tbl[s].div, tbl[s].sync);
      check($sformatf("tbl%0d_tick", s), bus.TICK_out, tbl[s].exp_tick);
      check($sformatf("tbl%0d_sqw", s), bus.SQW_out, tbl[s].exp_sqw);
    end

    // Load ch1 DIV=3 at cycle 4: current period completes at 10, then every 4.
    step(1'b0, 4'hF, 1'b0, 4'd0, 0, 1'b0);
    for (int s = 1; s <= 20; s++) begin
      if (s == 4) step(1'b1, 4'hF, 1'b1, 4'd1, 3, 1'b0);
      else        idle(4'hF);
      if (bus.TICK_out[1] === 1'b1) got_q.push_back(CW'(s));
      if (bus.TICK_out[0] === 1'b1) exp_q.push_back(CW'(s));
    end
    check_int("ch0_ticks_10_20", exp_q.size(), 2);
    exp_q.delete();
    exp_q.push_back(CW'(10)); exp_q.push_back(CW'(14)); exp_q.push_back(CW'(18));
    compare_queue("ch1_tick_at");

    // SYNC with channels at different counts (DIV 4,4,9,9).
    step(1'b0, 4'hF, 1'b0, 4'd0, 0, 1'b0);
    step(1'b1, 4'h0, 1'b1, 4'd0, 4, 1'b0);
    step(1'b1, 4'h0, 1'b1, 4'd1, 4, 1'b0);
    step(1'b1, 4'h0, 1'b1, 4'd2, 9, 1'b0);
    step(1'b1, 4'h0, 1'b1, 4'd3, 9, 1'b0);
    for (int s = 0; s < 6; s++) idle(4'hF);
    step(1'b1, 4'hF, 1'b0, 4'd0, 0, 1'b1);
    check("sync_tick", bus.TICK_out, 4'h0);
    check("sync_sqw", bus.SQW_out, 4'h0);
    for (int s = 1; s <= 12; s++) begin
      idle(4'hF);
      if (s == 5)  check("sync_tick5", bus.TICK_out, 4'b0011);
      if (s == 10) check("sync_tick10", bus.TICK_out, 4'b1111);
    end

    // EN[0] low for 7 cycles at cnt=5, then a load while stopped.
    step(1'b0, 4'hF, 1'b0, 4'd0, 0, 1'b0);
    for (int s = 0; s < 4; s++) idle(4'hF);
    for (int s = 0; s < 7; s++) idle(4'b1110);
    run_until(0, 4'hF, 12, k);
    check_int("reenable_tick_after", k, 6);
    step(1'b1, 4'b1110, 1'b1, 4'd0, 2, 1'b0);
    idle(4'b1110);
    run_until(0, 4'hF, 12, k);
    check_int("idle_load_tick_after", k, 3);

    // Reset together with LOAD and SYNC discards a pending load.
    for (int s = 0; s < 3; s++) idle(4'hF);
    step(1'b1, 4'hF, 1'b1, 4'd1, 2, 1'b0);
    step(1'b0, 4'hF, 1'b1, 4'd2, 1, 1'b1);
    check("rst_tick", bus.TICK_out, 4'h0);
    check("rst_sqw", bus.SQW_out, 4'h0);
    for (int s = 1; s <= 20; s++) begin
      idle(4'hF);
      if (bus.TICK_out[1] === 1'b1) got_q.push_back(CW'(s));
    end
    exp_q.push_back(CW'(10)); exp_q.push_back(CW'(20));
    compare_queue("rst_ch1_tick_at");

    // Random traffic against the model.
    for (int s = 0; s < 1500; s++) begin
      logic [CH-1:0] en;
      en = ($urandom_range(0, 7) == 0) ? CH'($urandom_range(0, 15)) : 4'hF;
      step(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, en,
           ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
           ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
- Multi-channel programmable clock-enable generator; successor to the power-of-2 ripple divider.
- Each channel divides the system clock by any integer ratio. It emits a single-cycle TICK enable for synchronous logic in the CLK_in domain, plus a 50%-duty square wave for slow display and blink uses.
- Divisors are runtime-loadable, with glitch-free change at the channel's terminal count.
- A global SYNC realigns all channel phases.
- Sits between the board clock and the calculator's debounce, display-scan and blink logic; consumers use TICK as an enable, never as a clock.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- CNT_W, 26, divisor/counter width in bits.
- DEFAULT_DIV, 49_999_999, reset divisor for every channel (1 Hz tick at 50 MHz).

Ports:
- CLK_in, input, 1: system clock, 50 MHz.
- RSTn_in, input, 1: synchronous active-low reset.
- EN_in, input, CHANNELS: per-channel run enable.
- LOAD_in, input, 1: divisor write strobe, one cycle.
- LOAD_SEL_in, input, 4: channel index for LOAD_in.
- DIV_in, input, CNT_W: divisor value; period P = DIV_in + 1 cycles.
- SYNC_in, input, 1: restart all channels in phase.
- TICK_out, output, CHANNELS: registered single-cycle enable pulse per period.
- SQW_out, output, CHANNELS: registered square wave, toggles each tick, period 2P.

Behaviour:
- Reset (RSTn_in low at posedge):
  - For every channel: div_active = div_pending = DEFAULT_DIV, cnt = DEFAULT_DIV, TICK_out = 0, SQW_out = 0.
  - Reset overrides LOAD, SYNC and EN in the same cycle.
- Per channel, each posedge with EN=1 and no SYNC:
  - If cnt == 0: cnt <= div_active' (div_pending if a load is pending, else div_active), TICK <= 1, SQW <= ~SQW, pending flag cleared.
  - Else: cnt <= cnt - 1, TICK <= 0.
- Latency:
  - The first TICK after reset or SYNC appears DIV+1 cycles later.
  - Ticks then repeat every DIV+1 cycles.
  - DIV = 0 gives TICK held high every cycle and SQW toggling every cycle (CLK_in/2).
- EN low:
  - cnt and SQW hold.
  - TICK forced 0 on the next edge.
  - Re-enabling resumes the count from the held value; there is no phase reset.
- LOAD_in:
  - Writes DIV_in into div_pending of channel LOAD_SEL_in and sets its pending flag.
  - Takes effect at that channel's next terminal count; the current period always completes.
  - A LOAD_SEL_in value >= CHANNELS is ignored, with no side effects.
  - Back-to-back loads before the terminal count: the last one wins.
  - If the channel's EN is 0 at the load, the value is also copied to div_active and cnt immediately.
- SYNC_in, one cycle, all channels regardless of EN:
  - cnt <= div_active' (pending applied), TICK <= 0, SQW <= 0, pending cleared.
  - SYNC takes priority over counting.
- Simultaneous LOAD and SYNC: the new divisor is written first, then applied by the SYNC, so the loaded channel restarts with the new value.
- Simultaneous LOAD and terminal count on the same channel: the new value is used for the reload; no tick is lost or duplicated.
- Outputs are glitch-free: every output is a flop Q with no combinational path from the inputs.
- Width rules:
  - cnt and div are unsigned CNT_W.
  - DIV_in is truncated to CNT_W.
  - No wrap below 0 is possible, because reload occurs at 0.

Decomposition:
- Shared clocking package/include (clocking_defs):
  - CLK_HZ = 50_000_000.
  - Ready divisor constants: DIV_1HZ = 49_999_999, DIV_1KHZ = 49_999, DIV_2HZ = 24_999_999, DIV_SCAN_1KHZ.
  - Default CNT_W.
- One sub-module, clk_en_channel:
  - Holds cnt, div_active, div_pending, pending flag, TICK and SQW for one channel.
  - Instantiated CHANNELS times by a generate loop.
  - The top decodes LOAD_SEL_in into per-channel load strobes and fans out SYNC_in.

Test Plan:
- Reset with DEFAULT_DIV overridden to 9, all EN = 1 -> first TICK on every channel at cycle 10 after reset release; ticks then every 10 cycles; SQW period 20 cycles, high 10 / low 10.
- LOAD ch1 DIV = 3 at cycle 4 of a 10-cycle period -> ch1 completes the current period (tick at cycle 10), then ticks every 4 cycles; other channels unchanged.
- DIV = 0 on ch2 -> TICK_out[2] high every cycle, SQW_out[2] toggles each cycle; LOAD_SEL_in = 7 with CHANNELS = 4 -> no channel state changes.
- SYNC mid-period with channels at differing counts (DIV 4, 4, 9, 9) -> all TICK = 0 and SQW = 0 next cycle; ch0/ch1 tick together 5 cycles after SYNC, ch2/ch3 10 cycles after.
- EN[0] low for 7 cycles mid-count (cnt = 5) -> TICK stays 0 and SQW holds; after re-enable, tick arrives 6 cycles later. LOAD while disabled, DIV = 2 -> applied immediately; tick 3 cycles after re-enable.
- RSTn_in low for 1 cycle mid-operation with LOAD and SYNC asserted simultaneously -> all channels return to DEFAULT_DIV, outputs 0, pending loads discarded.
